// File: rtl/sram_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Shares one single-port SRAM between three requesters (0 Wishbone, 1 mmul,
// 2 mconv) with round-robin arbitration. Each access takes four cycles:
// IDLE (grant) -> ISSUE (SRAM enable) -> RESP (capture read data) -> DONE.
// All outputs are registered.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   req[2:0]     access request per requester
//   we[2:0]      per requester: 1 write, 0 read
//   addr[95:0]   packed {addr2,addr1,addr0}, 32-bit word addresses
//   wdata[95:0]  packed {wdata2,wdata1,wdata0}
//   rdata        read data of the last completed read
//   done[2:0]    one-cycle completion pulse, one-hot to the served requester
//   err          address-range error flag, valid with done
//   busy         high in any state other than IDLE
//   gnt_id       index of the requester being served
//   sram_en      SRAM enable
//   sram_we      SRAM byte write enables
//   sram_addr    SRAM word address
//   sram_data_i  SRAM write data
//   sram_data_o  SRAM read data, valid the cycle after the enable cycle
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
   parameter int AWIDTH = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        req,
   input  logic [2:0]        we,
   input  logic [95:0]       addr,
   input  logic [95:0]       wdata,
   output logic [31:0]       rdata,
   output logic [2:0]        done,
   output logic              err,
   output logic              busy,
   output logic [1:0]        gnt_id,
   output logic              sram_en,
   output logic [3:0]        sram_we,
   output logic [AWIDTH-1:0] sram_addr,
   output logic [31:0]       sram_data_i,
   input  logic [31:0]       sram_data_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [1:0]        last_r, last_s;
   logic              we_lat_r, we_lat_s;
   logic              err_lat_r, err_lat_s;

   logic [31:0]       rdata_s;
   logic [2:0]        done_s;
   logic              err_s;
   logic              busy_s;
   logic [1:0]        gnt_s;
   logic              sram_en_s;
   logic [3:0]        sram_we_s;
   logic [AWIDTH-1:0] sram_addr_s;
   logic [31:0]       sram_data_s;

   logic [1:0]        win_s;
   logic [31:0]       sel_addr_s;
   logic [31:0]       sel_wdata_s;
   logic              sel_we_s;
   logic              range_err_s;

   // Round-robin pick: search starts one past the last granted requester.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
      logic [1:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      logic [1:0] pick;
      case (last)
         2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
         2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
         default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
      endcase
      if (r[c0]) begin
         pick = c0;
      end else if (r[c1]) begin
         pick = c1;
      end else begin
         pick = c2;
      end
      return pick;
   endfunction

   // Winner selection and the winner's request fields.
   always_comb begin
      win_s       = rr_pick(req, last_r);
      sel_addr_s  = addr[{win_s, 5'b00000} +: 32];
      sel_wdata_s = wdata[{win_s, 5'b00000} +: 32];
      sel_we_s    = we[win_s];
      // Any address bit above the SRAM width marks the access as out of range.
      range_err_s = (sel_addr_s >> AWIDTH) != 32'd0;
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that they are registered in the cycle of the state they belong to.
   always_comb begin
      state_s     = state_r;
      last_s      = last_r;
      we_lat_s    = we_lat_r;
      err_lat_s   = err_lat_r;
      rdata_s     = rdata;
      done_s      = 3'b000;
      err_s       = 1'b0;
      busy_s      = busy;
      gnt_s       = gnt_id;
      sram_en_s   = 1'b0;
      sram_we_s   = 4'b0000;
      sram_addr_s = sram_addr;
      sram_data_s = sram_data_i;
      case (state_r)
         ST_IDLE: begin
            if (req != 3'b000) begin
               state_s     = ST_ISSUE;
               last_s      = win_s;
               gnt_s       = win_s;
               we_lat_s    = sel_we_s;
               err_lat_s   = range_err_s;
               busy_s      = 1'b1;
               sram_en_s   = !range_err_s;
               sram_we_s   = (sel_we_s && !range_err_s) ? 4'b1111 : 4'b0000;
               sram_addr_s = sel_addr_s[AWIDTH-1:0];
               if (sel_we_s) begin
                  sram_data_s = sel_wdata_s;
               end else begin
                  sram_data_s = sram_data_i;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_s = ST_RESP;
         end
         ST_RESP: begin
            state_s = ST_DONE;
            done_s  = 3'b001 << gnt_id;
            err_s   = err_lat_r;
            if (we_lat_r) begin
               rdata_s = rdata;
            end else if (err_lat_r) begin
               rdata_s = 32'd0;
            end else begin
               rdata_s = sram_data_o;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State, arbitration history and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         last_r      <= 2'd2;
         we_lat_r    <= 1'b0;
         err_lat_r   <= 1'b0;
         rdata       <= 32'd0;
         done        <= 3'b000;
         err         <= 1'b0;
         busy        <= 1'b0;
         gnt_id      <= 2'd0;
         sram_en     <= 1'b0;
         sram_we     <= 4'b0000;
         sram_addr   <= '0;
         sram_data_i <= 32'd0;
      end else begin
         state_r     <= state_s;
         last_r      <= last_s;
         we_lat_r    <= we_lat_s;
         err_lat_r   <= err_lat_s;
         rdata       <= rdata_s;
         done        <= done_s;
         err         <= err_s;
         busy        <= busy_s;
         gnt_id      <= gnt_s;
         sram_en     <= sram_en_s;
         sram_we     <= sram_we_s;
         sram_addr   <= sram_addr_s;
         sram_data_i <= sram_data_s;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Self-checking bench for sram_port_arbiter with a behavioural SRAM and a
// transaction-level reference model (round-robin order, memory contents,
// read-data register).
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

   localparam int AWIDTH = 9;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [2:0]        req;
   logic [2:0]        we;
   logic [31:0]       a_q [3];
   logic [31:0]       d_q [3];
   logic [95:0]       addr;
   logic [95:0]       wdata;
   logic [31:0]       rdata;
   logic [2:0]        done;
   logic              err;
   logic              busy;
   logic [1:0]        gnt_id;
   logic              sram_en;
   logic [3:0]        sram_we;
   logic [AWIDTH-1:0] sram_addr;
   logic [31:0]       sram_data_i;
   logic [31:0]       sram_data_o;

   logic [31:0]       mem [512];
   logic [31:0]       ref_mem [512];
   int                ref_last;
   logic [31:0]       ref_rdata;

   int n_checks = 0;
   int n_errors = 0;

   assign addr  = {a_q[2], a_q[1], a_q[0]};
   assign wdata = {d_q[2], d_q[1], d_q[0]};

   sram_port_arbiter #(.AWIDTH(AWIDTH)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .done(done), .err(err), .busy(busy), .gnt_id(gnt_id),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_data_i(sram_data_i), .sram_data_o(sram_data_o)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: read data appears the cycle after the enable cycle.
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we == 4'b1111) mem[sram_addr] <= sram_data_i;
         else sram_data_o <= mem[sram_addr];
      end
   end

   typedef struct {
      logic        en1;
      logic [3:0]  we1;
      logic [8:0]  addr1;
      logic [31:0] di1;
      logic [1:0]  gnt;
      logic        busy1;
      logic        en2;
      logic [2:0]  done;
      logic        err;
      logic [31:0] rdata;
      logic [2:0]  done4;
      logic        busy4;
   } obs_t;

   typedef struct {
      logic [1:0]  win;
      logic        err;
      logic        en1;
      logic [3:0]  we1;
      logic [8:0]  addr1;
      logic [31:0] di1;
      logic [2:0]  done;
      logic [31:0] rdata;
   } exp_t;

   // Reference model: one whole transaction from the rules, updating state.
   task automatic model_predict(input logic [2:0] r, output exp_t e);
      bit   found = 0;
      logic [31:0] a;
      e.win = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         int idx = (ref_last + k) % 3;
         if (!found && r[idx]) begin
            e.win = 2'(idx);
            found = 1;
         end
      end
      ref_last = int'(e.win);
      a        = a_q[e.win];
      e.err    = (a >= (32'd1 << AWIDTH));
      e.en1    = !e.err;
      e.we1    = (we[e.win] && !e.err) ? 4'b1111 : 4'b0000;
      e.addr1  = a[8:0];
      e.di1    = d_q[e.win];
      e.done   = 3'b001 << e.win;
      if (!we[e.win]) ref_rdata = e.err ? 32'd0 : ref_mem[a[8:0]];
      else if (!e.err) ref_mem[a[8:0]] = d_q[e.win];
      e.rdata  = ref_rdata;
   endtask

   // Drive one request from an IDLE cycle and record the four access cycles.
   task automatic access(input logic [2:0] r, output obs_t o);
      req = r;
      @(posedge clk); #1;
      o.en1 = sram_en; o.we1 = sram_we; o.addr1 = sram_addr; o.di1 = sram_data_i;
      o.gnt = gnt_id;  o.busy1 = busy;
      @(posedge clk); #1;
      o.en2 = sram_en | (|sram_we);
      @(posedge clk); #1;
      o.done = done; o.err = err; o.rdata = rdata;
      req = 3'b000;
      @(posedge clk); #1;
      o.done4 = done; o.busy4 = busy;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req = 3'b000; we = 3'b000;
      for (int i = 0; i < 3; i++) begin a_q[i] = 32'd0; d_q[i] = 32'd0; end
      ref_last = 2; ref_rdata = 32'd0;
      #2;
      n_checks++;
      if ({rdata, done, err, busy, gnt_id, sram_en, sram_we, sram_addr, sram_data_i} !== '0) begin
         n_errors++; $display("FAIL reset_outputs: got nonzero rdata=%h done=%b busy=%b gnt=%0d en=%b", rdata, done, busy, gnt_id, sram_en);
      end
      #20 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 3'b000) begin
         n_errors++; $display("FAIL reset_idle: busy=%b done=%b required 0/000", busy, done);
      end
   endtask

   task automatic test_single_read();
      obs_t o; exp_t e;
      a_q[0] = 32'd5; we = 3'b000;
      model_predict(3'b001, e);
      access(3'b001, o);
      n_checks++;
      if (o.en1 !== 1'b1 || o.addr1 !== 9'd5) begin
         n_errors++; $display("FAIL read_issue: en=%b addr=%h required 1/005", o.en1, o.addr1);
      end
      n_checks++;
      if (o.done !== 3'b001 || o.rdata !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL read_done: done=%b rdata=%h required 001/deadbeef", o.done, o.rdata);
      end
      n_checks++;
      if (o.en2 !== 1'b0 || o.done4 !== 3'b000) begin
         n_errors++; $display("FAIL read_pulse_len: en2=%b done4=%b required 0/000", o.en2, o.done4);
      end
   endtask

   task automatic test_write();
      obs_t o; exp_t e;
      a_q[1] = 32'h1F; d_q[1] = 32'h12345678; we = 3'b010;
      model_predict(3'b010, e);
      access(3'b010, o);
      n_checks++;
      if (o.en1 !== 1'b1 || o.we1 !== 4'b1111 || o.di1 !== 32'h12345678) begin
         n_errors++; $display("FAIL write_issue: en=%b we=%b data=%h required 1/1111/12345678", o.en1, o.we1, o.di1);
      end
      n_checks++;
      if (o.done !== 3'b010 || o.err !== 1'b0 || o.gnt !== 2'd1) begin
         n_errors++; $display("FAIL write_done: done=%b err=%b gnt=%0d required 010/0/1", o.done, o.err, o.gnt);
      end
      a_q[0] = 32'h1F; we = 3'b000;
      model_predict(3'b001, e);
      access(3'b001, o);
      n_checks++;
      if (o.rdata !== 32'h12345678) begin
         n_errors++; $display("FAIL write_readback: got %h required 12345678", o.rdata);
      end
   endtask

   task automatic test_fairness();
      obs_t o; exp_t e;
      int start = (ref_last + 1) % 3;
      we = 3'b000;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 3; j++) a_q[j] = $urandom_range(0, 511);
         model_predict(3'b111, e);
         access(3'b111, o);
         n_checks++;
         if (o.gnt !== 2'((start + i) % 3) || o.done !== (3'b001 << ((start + i) % 3))) begin
            n_errors++; $display("FAIL fairness_%0d: gnt=%0d done=%b required gnt %0d", i, o.gnt, o.done, (start + i) % 3);
         end
         n_checks++;
         if (o.rdata !== e.rdata) begin
            n_errors++; $display("FAIL fairness_rdata_%0d: got %h required %h", i, o.rdata, e.rdata);
         end
      end
   endtask

   task automatic test_range_error();
      obs_t o; exp_t e;
      a_q[2] = 32'h0000_0200; we = 3'b000;
      model_predict(3'b100, e);
      access(3'b100, o);
      n_checks++;
      if (o.en1 !== 1'b0 || o.we1 !== 4'b0000 || o.en2 !== 1'b0) begin
         n_errors++; $display("FAIL range_suppress: en1=%b we1=%b en2=%b required 0/0000/0", o.en1, o.we1, o.en2);
      end
      n_checks++;
      if (o.done !== 3'b100 || o.err !== 1'b1 || o.rdata !== 32'd0) begin
         n_errors++; $display("FAIL range_done: done=%b err=%b rdata=%h required 100/1/0", o.done, o.err, o.rdata);
      end
      n_checks++;
      if (o.done4 !== 3'b000 || o.busy4 !== 1'b0) begin
         n_errors++; $display("FAIL range_end: done4=%b busy4=%b required 000/0", o.done4, o.busy4);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o; exp_t e;
      a_q[0] = 32'd5; we = 3'b000; req = 3'b001;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({rdata, done, err, busy, gnt_id, sram_en, sram_we, sram_addr, sram_data_i} !== '0) begin
         n_errors++; $display("FAIL reset_mid_outputs: rdata=%h done=%b busy=%b en=%b", rdata, done, busy, sram_en);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (done !== 3'b000) begin
            n_errors++; $display("FAIL reset_mid_nodone_%0d: done=%b required 000", i, done);
         end
      end
      reset_n = 1'b1;
      ref_last = 2; ref_rdata = 32'd0;
      model_predict(3'b001, e);
      access(3'b001, o);
      n_checks++;
      if (o.en1 !== 1'b1 || o.done !== 3'b001 || o.rdata !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL reset_mid_after: en=%b done=%b rdata=%h required 1/001/deadbeef", o.en1, o.done, o.rdata);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      a_q[0] = $urandom_range(0, 511); we = 3'b000;
      for (int i = 0; i < 4; i++) model_predict(3'b001, e);
      req = 3'b001;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (done !== ((k % 4 == 3) ? 3'b001 : 3'b000) || busy !== (k % 4 != 0)) begin
            n_errors++; $display("FAIL b2b_cycle_%0d: done=%b busy=%b", k, done, busy);
         end
         if (k % 4 == 3) begin
            n_checks++;
            if (rdata !== e.rdata) begin
               n_errors++; $display("FAIL b2b_rdata_%0d: got %h required %h", k, rdata, e.rdata);
            end
         end
         if (k == 15) req = 3'b000;
      end
   endtask

   task automatic test_random();
      obs_t o; exp_t e;
      logic [2:0] r;
      for (int i = 0; i < 40; i++) begin
         r  = 3'($urandom_range(1, 7));
         we = 3'($urandom_range(0, 7));
         for (int j = 0; j < 3; j++) begin
            a_q[j] = ($urandom % 5 == 0) ? ($urandom | 32'h0000_0200) : 32'($urandom_range(0, 511));
            d_q[j] = $urandom;
         end
         model_predict(r, e);
         access(r, o);
         n_checks++;
         if (o.gnt !== e.win || o.done !== e.done || o.err !== e.err) begin
            n_errors++; $display("FAIL rand_grant_%0d: gnt=%0d done=%b err=%b required %0d/%b/%b", i, o.gnt, o.done, o.err, e.win, e.done, e.err);
         end
         n_checks++;
         if (o.en1 !== e.en1 || o.we1 !== e.we1 || o.en2 !== 1'b0) begin
            n_errors++; $display("FAIL rand_issue_%0d: en=%b we=%b en2=%b required %b/%b/0", i, o.en1, o.we1, o.en2, e.en1, e.we1);
         end
         if (e.en1) begin
            n_checks++;
            if (o.addr1 !== e.addr1 || (e.we1 == 4'b1111 && o.di1 !== e.di1)) begin
               n_errors++; $display("FAIL rand_addr_%0d: addr=%h data=%h required %h/%h", i, o.addr1, o.di1, e.addr1, e.di1);
            end
         end
         n_checks++;
         if (o.rdata !== e.rdata) begin
            n_errors++; $display("FAIL rand_rdata_%0d: got %h required %h", i, o.rdata, e.rdata);
         end
         n_checks++;
         if (o.busy1 !== 1'b1 || o.busy4 !== 1'b0 || o.done4 !== 3'b000) begin
            n_errors++; $display("FAIL rand_busy_%0d: busy1=%b busy4=%b done4=%b", i, o.busy1, o.busy4, o.done4);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         logic [31:0] v;
         v = (i == 5) ? 32'hDEADBEEF : $urandom;
         mem[i]     <= v;
         ref_mem[i]  = v;
      end
      test_reset();
      test_single_read();
      test_write();
      test_fairness();
      test_range_error();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
